// File: rtl/motion_diff_reader.sv
// Read-side master of the ping-pong frame buffer: raster-scans one frame, streams |curr-prev|
// motion beats through a 3-entry skid FIFO and keeps a per-frame motion summary.
module motion_diff_reader #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int DEPTH  = WIDTH * HEIGHT
) (
    input  logic        rclk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  thresh,
    input  logic        buffer_sel,
    output logic        rd_oe,
    output logic [14:0] rd_addr,
    input  logic [7:0]  curr_data,
    input  logic [7:0]  prev_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_diff,
    output logic        m_motion,
    output logic [7:0]  m_x,
    output logic [6:0]  m_y,
    output logic        m_last,
    output logic        busy,
    output logic        frame_done,
    output logic [14:0] motion_count,
    output logic [7:0]  bbox_min_x,
    output logic [7:0]  bbox_max_x,
    output logic [6:0]  bbox_min_y,
    output logic [6:0]  bbox_max_y,
    output logic        bbox_valid,
    output logic        frame_torn
);
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
    localparam logic [7:0]  LAST_X    = 8'(WIDTH - 1);
    localparam logic [6:0]  LAST_Y    = 7'(HEIGHT - 1);

    state_t      state_r, state_s;
    logic [7:0]  thresh_r;
    logic        sel_r;
    logic        pend_r;
    logic [7:0]  cap_x_r;
    logic [6:0]  cap_y_r;
    // beat layout: {diff[24:17], motion[16], x[15:8], y[7:1], last[0]}
    logic [24:0] fifo_mem_r [0:2];
    logic [1:0]  wr_ptr_r, rd_ptr_r, fifo_count_r;
    logic [14:0] count_r;
    logic [7:0]  min_x_r, max_x_r;
    logic [6:0]  min_y_r, max_y_r;
    logic        torn_r;
    logic        start_acc_s, push_s, pop_s;
    logic [24:0] head_s, beat_s;
    logic [8:0]  sub_s, neg_s;
    logic [7:0]  diff_s;

    assign start_acc_s = (state_r == IDLE) && start;
    assign push_s      = pend_r;
    assign pop_s       = m_valid && m_ready;

    // State register
    always_ff @(posedge rclk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start) state_s = SCAN; else state_s = IDLE;
            SCAN:    if (rd_oe && (rd_addr == LAST_ADDR)) state_s = DRAIN; else state_s = SCAN;
            DRAIN:   if (pop_s && head_s[0]) state_s = DONE; else state_s = DRAIN;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs; read credit counts FIFO occupancy plus the read still in flight
    always_comb begin
        rd_oe      = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_r)
            IDLE:    busy = 1'b0;
            SCAN:    rd_oe = ({1'b0, fifo_count_r} + {2'b00, pend_r}) < 3'd3;
            DRAIN:   busy = 1'b1;
            DONE:    frame_done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Read address, in-flight flag, latched frame settings and capture coordinates
    always_ff @(posedge rclk) begin
        if (reset) begin
            rd_addr  <= 15'd0;
            pend_r   <= 1'b0;
            thresh_r <= 8'd0;
            sel_r    <= 1'b0;
            cap_x_r  <= 8'd0;
            cap_y_r  <= 7'd0;
        end else begin
            pend_r <= rd_oe;
            if (start_acc_s) begin
                rd_addr  <= 15'd0;
                thresh_r <= thresh;
                sel_r    <= buffer_sel;
                cap_x_r  <= 8'd0;
                cap_y_r  <= 7'd0;
            end else begin
                if (rd_oe && (rd_addr != LAST_ADDR)) rd_addr <= rd_addr + 15'd1;
                if (pend_r) begin
                    if (cap_x_r == LAST_X) begin
                        cap_x_r <= 8'd0;
                        cap_y_r <= cap_y_r + 7'd1;
                    end else begin
                        cap_x_r <= cap_x_r + 8'd1;
                    end
                end
            end
        end
    end

    // Absolute difference via a 9-bit signed subtract, then beat assembly
    always_comb begin
        sub_s  = {1'b0, curr_data} - {1'b0, prev_data};
        neg_s  = 9'd0 - sub_s;
        diff_s = sub_s[8] ? neg_s[7:0] : sub_s[7:0];
        beat_s = {diff_s, (diff_s > thresh_r), cap_x_r, cap_y_r,
                  ((cap_x_r == LAST_X) && (cap_y_r == LAST_Y))};
    end

    // FIFO head mux
    always_comb begin
        case (rd_ptr_r)
            2'd0:    head_s = fifo_mem_r[0];
            2'd1:    head_s = fifo_mem_r[1];
            default: head_s = fifo_mem_r[2];
        endcase
    end

    // FIFO storage and pointers; never overflows because reads are issued against the credit
    always_ff @(posedge rclk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) fifo_mem_r[i] <= 25'd0;
            wr_ptr_r     <= 2'd0;
            rd_ptr_r     <= 2'd0;
            fifo_count_r <= 2'd0;
        end else begin
            if (push_s) begin
                case (wr_ptr_r)
                    2'd0:    fifo_mem_r[0] <= beat_s;
                    2'd1:    fifo_mem_r[1] <= beat_s;
                    default: fifo_mem_r[2] <= beat_s;
                endcase
                wr_ptr_r <= (wr_ptr_r == 2'd2) ? 2'd0 : wr_ptr_r + 2'd1;
            end
            if (pop_s) rd_ptr_r <= (rd_ptr_r == 2'd2) ? 2'd0 : rd_ptr_r + 2'd1;
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + 2'd1;
                2'b01:   fifo_count_r <= fifo_count_r - 2'd1;
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Per-frame summary: accumulates on accepted motion beats, held until the next start
    always_ff @(posedge rclk) begin
        if (reset || start_acc_s) begin
            count_r <= 15'd0;
            min_x_r <= 8'd255;
            max_x_r <= 8'd0;
            min_y_r <= 7'd127;
            max_y_r <= 7'd0;
            torn_r  <= 1'b0;
        end else begin
            if (pop_s && head_s[16]) begin
                count_r <= count_r + 15'd1;
                if (head_s[15:8] < min_x_r) min_x_r <= head_s[15:8];
                if (head_s[15:8] > max_x_r) max_x_r <= head_s[15:8];
                if (head_s[7:1] < min_y_r)  min_y_r <= head_s[7:1];
                if (head_s[7:1] > max_y_r)  max_y_r <= head_s[7:1];
            end
            if (((state_r == SCAN) || (state_r == DRAIN)) && (buffer_sel != sel_r)) torn_r <= 1'b1;
        end
    end

    // Stream and summary output mapping
    always_comb begin
        m_valid      = (fifo_count_r != 2'd0);
        m_diff       = head_s[24:17];
        m_motion     = head_s[16];
        m_x          = head_s[15:8];
        m_y          = head_s[7:1];
        m_last       = m_valid && head_s[0];
        motion_count = count_r;
        bbox_valid   = (count_r != 15'd0);
        frame_torn   = torn_r;
        if (bbox_valid) begin
            bbox_min_x = min_x_r;
            bbox_max_x = max_x_r;
            bbox_min_y = min_y_r;
            bbox_max_y = max_y_r;
        end else begin
            bbox_min_x = 8'd0;
            bbox_max_x = 8'd0;
            bbox_min_y = 7'd0;
            bbox_max_y = 7'd0;
        end
    end
endmodule

// File: tb/tb_motion_diff_reader.sv
// Directed frame scans against a pixel-array reference model of the motion reader.
module tb_motion_diff_reader;
    localparam int W = 160;
    localparam int H = 120;
    localparam int D = W * H;

    logic        rclk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  thresh = 8'd0;
    logic        buffer_sel = 1'b0;
    logic        rd_oe;
    logic [14:0] rd_addr;
    logic [7:0]  curr_data = 8'd0;
    logic [7:0]  prev_data = 8'd0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_diff;
    logic        m_motion;
    logic [7:0]  m_x;
    logic [6:0]  m_y;
    logic        m_last;
    logic        busy;
    logic        frame_done;
    logic [14:0] motion_count;
    logic [7:0]  bbox_min_x, bbox_max_x;
    logic [6:0]  bbox_min_y, bbox_max_y;
    logic        bbox_valid;
    logic        frame_torn;

    logic [7:0] cmem [0:D-1];
    logic [7:0] pmem [0:D-1];
    int checks = 0;
    int errors = 0;

    motion_diff_reader dut (
        .rclk(rclk), .reset(reset), .start(start), .thresh(thresh), .buffer_sel(buffer_sel),
        .rd_oe(rd_oe), .rd_addr(rd_addr), .curr_data(curr_data), .prev_data(prev_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_diff(m_diff), .m_motion(m_motion),
        .m_x(m_x), .m_y(m_y), .m_last(m_last), .busy(busy), .frame_done(frame_done),
        .motion_count(motion_count), .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
        .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y), .bbox_valid(bbox_valid),
        .frame_torn(frame_torn)
    );

    always #5 rclk = ~rclk;

    // frame buffer with one cycle of read latency
    always @(posedge rclk) begin
        if (rd_oe) begin
            curr_data <= cmem[rd_addr];
            prev_data <= pmem[rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input logic [7:0] th, input bit rnd, input int torn_at,
                             input int start_at, input int rst_at);
        int idx = 0, iss = 0, outst = 0, cyc = 0, first_v = -1, last_cyc = -1;
        int e_cnt = 0, e_minx = 255, e_maxx = 0, e_miny = 127, e_maxy = 0;
        int d, bx, by;
        bit fin = 1'b0, acc, toggled = 1'b0;
        logic [24:0] exp_beat;
        for (int i = 0; i < D; i++) begin
            d = int'(cmem[i]) - int'(pmem[i]);
            if (d < 0) d = -d;
            if (d > int'(th)) begin
                e_cnt++;
                if (i % W < e_minx) e_minx = i % W;
                if (i % W > e_maxx) e_maxx = i % W;
                if (i / W < e_miny) e_miny = i / W;
                if (i / W > e_maxy) e_maxy = i / W;
            end
        end
        start = 1'b1;
        thresh = th;
        while (!fin && cyc < 60000) begin
            @(negedge rclk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                thresh = 8'($urandom);
                chk("clr_count", 32'(motion_count), 32'd0);
                chk("clr_torn", 32'(frame_torn), 32'd0);
                chk("busy_scan", 32'(busy), 32'd1);
            end
            if (first_v < 0 && m_valid) first_v = cyc;
            chk("credit", 32'((outst + int'(rd_oe)) <= 3), 32'd1);
            if (rd_oe) begin
                chk("rd_addr", 32'(rd_addr), 32'(iss));
                iss++;
            end
            m_ready = rnd ? 1'($urandom) : 1'b1;
            acc = m_valid && m_ready;
            if (acc) begin
                d = int'(cmem[idx]) - int'(pmem[idx]);
                if (d < 0) d = -d;
                bx = idx % W;
                by = idx / W;
                exp_beat = {8'(d), (d > int'(th)), 8'(bx), 7'(by), (idx == D - 1)};
                chk("beat", 32'({m_diff, m_motion, m_x, m_y, m_last}), 32'(exp_beat));
                idx++;
                last_cyc = cyc;
            end
            outst = outst + int'(rd_oe) - int'(acc);
            if (torn_at >= 0 && iss == torn_at && !toggled) begin
                buffer_sel = ~buffer_sel;
                toggled = 1'b1;
            end
            if (start_at >= 0 && iss == start_at) start = 1'b1;
            if (rst_at >= 0 && iss == rst_at) begin
                chk("pre_rst_count", 32'(motion_count != 15'd0), 32'd1);
                reset = 1'b1;
                @(negedge rclk);
                reset = 1'b0;
                chk("rst_rd_oe", 32'(rd_oe), 32'd0);
                chk("rst_rd_addr", 32'(rd_addr), 32'd0);
                chk("rst_m_valid", 32'({m_valid, m_last}), 32'd0);
                chk("rst_busy_done", 32'({busy, frame_done}), 32'd0);
                chk("rst_summary", 32'({motion_count, bbox_valid, frame_torn}), 32'd0);
                chk("rst_bbox", 32'({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}), 32'd0);
                return;
            end
            if (frame_done) begin
                fin = 1'b1;
                chk("beat_total", 32'(idx), 32'(D));
                chk("done_latency", 32'(cyc), 32'(last_cyc + 1));
            end
        end
        chk("frame_timeout", 32'(fin), 32'd1);
        chk("first_latency", 32'(first_v), 32'd3);
        chk("motion_count", 32'(motion_count), 32'(e_cnt));
        chk("bbox_valid", 32'(bbox_valid), 32'(e_cnt != 0));
        if (e_cnt == 0) begin
            e_minx = 0; e_maxx = 0; e_miny = 0; e_maxy = 0;
        end
        chk("bbox", 32'({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}),
            32'({8'(e_minx), 8'(e_maxx), 7'(e_miny), 7'(e_maxy)}));
        chk("frame_torn", 32'(frame_torn), 32'(torn_at >= 0));
        @(negedge rclk);
        chk("done_pulse", 32'({frame_done, busy}), 32'd0);
        repeat (5) @(negedge rclk);
        chk("hold_count", 32'(motion_count), 32'(e_cnt));
        chk("hold_torn", 32'(frame_torn), 32'(torn_at >= 0));
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            cmem[i] = 8'($urandom);
            pmem[i] = cmem[i];
        end
        repeat (3) @(negedge rclk);
        reset = 1'b0;
        chk("reset_outputs", 32'({rd_oe, m_valid, m_last, busy, frame_done, bbox_valid, frame_torn}), 32'd0);
        chk("reset_addr", 32'(rd_addr), 32'd0);
        chk("reset_summary", 32'({motion_count, bbox_min_x}), 32'd0);

        // identical frames: no motion anywhere
        run_frame(8'd30, 1'b0, -1, -1, -1);

        // single moving pixel at (21,10), a diff-30 pixel below threshold, torn buffer flag
        cmem[1621] = 8'd200;
        pmem[1621] = 8'd100;
        cmem[50] = 8'd130;
        pmem[50] = 8'd100;
        run_frame(8'd30, 1'b0, 8000, -1, -1);
        chk("bbox_1621", 32'({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}),
            32'({8'd21, 8'd21, 7'd10, 7'd10}));
        chk("count_1621", 32'(motion_count), 32'd1);

        // sparse random motion in a window plus threshold boundary pixels
        for (int i = 0; i < D; i++) begin
            cmem[i] = 8'($urandom);
            pmem[i] = cmem[i];
            if ((i % W) >= 30 && (i % W) <= 130 && (i / W) >= 20 && (i / W) <= 100
                && ($urandom % 50) == 0) pmem[i] = 8'($urandom);
        end
        cmem[7] = 8'd100; pmem[7] = 8'd131;
        cmem[8] = 8'd60;  pmem[8] = 8'd30;
        cmem[9] = 8'd5;   pmem[9] = 8'd250;

        // ignored mid-scan start, then reset aborts the scan
        run_frame(8'd30, 1'b0, -1, 2000, 5000);
        repeat (2) @(negedge rclk);

        // full rescan from address 0 with random downstream stalls
        run_frame(8'd30, 1'b1, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
